// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings and types for the MIPS-lite execute-stage arithmetic block.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned GOUT_W  = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FNIB_W  = 4;

  typedef enum logic [GOUT_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ORI    = 2'b11
  } aluop_e;

  // Low nibble of the R-type funct field.
  localparam logic [FNIB_W-1:0] FUNCT_ADD = 4'b0000;
  localparam logic [FNIB_W-1:0] FUNCT_SUB = 4'b0010;
  localparam logic [FNIB_W-1:0] FUNCT_AND = 4'b0100;
  localparam logic [FNIB_W-1:0] FUNCT_OR  = 4'b0101;
  localparam logic [FNIB_W-1:0] FUNCT_NOR = 4'b0111;
  localparam logic [FNIB_W-1:0] FUNCT_SLT = 4'b1010;

  typedef struct packed {
    logic v;
    logic z;
    logic n;
  } status_flags_t;

endpackage

// File: rtl/alu_exec_unit_alu_op_decoder.sv
// ALU-control decoder: ALUOp plus funct low nibble to a 3-bit ALU operation.
module alu_op_decoder
  import alu_exec_unit_pkg::*;
(
  input  logic              aluop1_i,
  input  logic              aluop0_i,
  input  logic [FNIB_W-1:0] funct_i,
  output alu_op_e           gout_o
);

  always_comb begin
    gout_o = ALU_ADD;
    case (aluop_e'({aluop1_i, aluop0_i}))
      ALUOP_MEM:    gout_o = ALU_ADD;
      ALUOP_BRANCH: gout_o = ALU_SUB;
      ALUOP_ORI:    gout_o = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: gout_o = ALU_ADD;
          FUNCT_SUB: gout_o = ALU_SUB;
          FUNCT_AND: gout_o = ALU_AND;
          FUNCT_OR:  gout_o = ALU_OR;
          FUNCT_NOR: gout_o = ALU_NOR;
          FUNCT_SLT: gout_o = ALU_SLT;
          default:   gout_o = ALU_ADD;
        endcase
      end
      default: gout_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control, 32-bit ALU with flags, PC adders and V/Z/N status register.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aluop1,
  input  logic             aluop0,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm_ext,
  output logic [2:0]       gout,
  output logic [WIDTH-1:0] alu_result,
  output logic             zout,
  output logic             vout,
  output logic             nout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  alu_op_e       alu_op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic          add_ovf;
  logic          sub_ovf;
  status_flags_t flags_d;
  status_flags_t flags_q;
  logic          unused_bits;

  assign unused_bits = ^{funct[5:4], imm_ext[WIDTH-1:WIDTH-2]};

  alu_op_decoder u_dec (
    .aluop1_i (aluop1),
    .aluop0_i (aluop0),
    .funct_i  (funct[3:0]),
    .gout_o   (alu_op)
  );

  assign gout = alu_op;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // SLT uses sign-of-difference corrected by overflow so extreme operands compare right.
  always_comb begin
    alu_result = '0;
    vout       = 1'b0;
    case (alu_op)
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_NOR: alu_result = ~(a | b);
      ALU_ADD: begin
        alu_result = sum;
        vout       = add_ovf;
      end
      ALU_SUB: begin
        alu_result = diff;
        vout       = sub_ovf;
      end
      ALU_SLT: alu_result = {(WIDTH-1)'(0), diff[WIDTH-1] ^ sub_ovf};
      default: alu_result = '0;
    endcase
  end

  assign zout = (alu_result == '0);
  assign nout = alu_result[WIDTH-1];

  assign pc_plus4      = pc + WIDTH'(4);
  assign branch_target = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};

  assign flags_d = '{v: vout, z: zout, n: nout};

  // Status register samples every edge; reset clears it asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign v_flag = flags_q.v;
  assign z_flag = flags_q.z;
  assign n_flag = flags_q.n;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, flag sequences, random vs. model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b, pc, imm_ext;
  logic [2:0]  gout;
  logic [31:0] alu_result, pc_plus4, branch_target;
  logic        zout, vout, nout, v_flag, z_flag, n_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .aluop1(aluop[1]), .aluop0(aluop[0]), .funct(funct),
    .a(a), .b(b), .pc(pc), .imm_ext(imm_ext), .gout(gout), .alu_result(alu_result),
    .zout(zout), .vout(vout), .nout(nout), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .v_flag(v_flag), .z_flag(z_flag), .n_flag(n_flag)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  eg;
    logic [31:0] er;
    logic        ev;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the architectural rules using wide signed arithmetic.
  task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, output logic [2:0] g, output logic [31:0] r,
                       output logic v);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'd0: g = 3'b010;
      2'd1: g = 3'b110;
      2'd3: g = 3'b001;
      default: begin
        case (f[3:0])
          4'h0: g = 3'b010;
          4'h2: g = 3'b110;
          4'h4: g = 3'b000;
          4'h5: g = 3'b001;
          4'h7: g = 3'b100;
          4'hA: g = 3'b111;
          default: g = 3'b010;
        endcase
      end
    endcase
    r = 32'h0;
    v = 1'b0;
    case (g)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = ~(x | y);
      3'b010: begin
        s = sx + sy;
        r = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s = sx - sy;
        r = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 7))
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      4: return 6'h27;
      5: return 6'h2A;
      default: return 6'($urandom());
    endcase
  endfunction

  task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    aluop = op; funct = f; a = x; b = y;
    #1;
  endtask

  task automatic chk_flags(input string name, input logic [2:0] exp);
    chk(name, 32'({v_flag, z_flag, n_flag}), 32'(exp));
  endtask

  initial begin
    logic [2:0]  mg;
    logic [31:0] mr, mpc, mimm;
    logic        mv;

    vecs[0]  = '{2'd2, 6'h20, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b1};
    vecs[1]  = '{2'd1, 6'h00, 32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b0};
    vecs[2]  = '{2'd1, 6'h00, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{2'd2, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0};
    vecs[4]  = '{2'd2, 6'h2A, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b0};
    vecs[5]  = '{2'd2, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0};
    vecs[6]  = '{2'd2, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0};
    vecs[7]  = '{2'd2, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0};
    vecs[8]  = '{2'd2, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 32'h000F000F, 1'b0};
    vecs[9]  = '{2'd3, 6'h00, 32'hF0F0F0F0, 32'h0000FFFF, 3'b001, 32'hF0F0FFFF, 1'b0};
    vecs[10] = '{2'd2, 6'h22, 32'h00000005, 32'h00000007, 3'b110, 32'hFFFFFFFE, 1'b0};
    vecs[11] = '{2'd2, 6'h2F, 32'h00000003, 32'h00000004, 3'b010, 32'h00000007, 1'b0};
    vecs[12] = '{2'd0, 6'h00, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0};

    rst = 1'b1; aluop = 2'd0; funct = 6'h0; a = '0; b = '0; pc = '0; imm_ext = '0;
    #1;
    chk_flags("reset_flags", 3'b000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].op, vecs[i].fn, vecs[i].x, vecs[i].y);
      chk($sformatf("vec%0d_gout", i), 32'(gout), 32'(vecs[i].eg));
      chk($sformatf("vec%0d_result", i), alu_result, vecs[i].er);
      chk($sformatf("vec%0d_vout", i), 32'(vout), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_zout", i), 32'(zout), 32'(vecs[i].er == 32'h0));
      chk($sformatf("vec%0d_nout", i), 32'(nout), 32'(vecs[i].er[31]));
    end

    @(negedge clk);
    pc = 32'h0000001C; imm_ext = 32'hFFFFFFFE;
    #1;
    chk("pc_plus4", pc_plus4, 32'h00000020);
    chk("branch_target", branch_target, 32'h00000018);
    @(negedge clk);
    pc = 32'hFFFFFFFC; imm_ext = 32'h00000000;
    #1;
    chk("pc_plus4_wrap", pc_plus4, 32'h00000000);
    chk("branch_target_wrap", branch_target, 32'h00000000);

    // Status register capture, async reset, and first edge after release.
    apply(2'd2, 6'h20, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    chk_flags("flags_add_ovf", 3'b101);
    apply(2'd1, 6'h00, 32'h12345678, 32'h12345678);
    @(posedge clk); #1;
    chk_flags("flags_beq_zero", 3'b010);
    apply(2'd2, 6'h20, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    chk_flags("flags_set_again", 3'b101);
    rst = 1'b1;
    #1;
    chk_flags("flags_async_clear", 3'b000);
    @(posedge clk); #1;
    chk_flags("flags_held_in_reset", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_flags("flags_after_release", 3'b000);
    @(posedge clk); #1;
    chk_flags("flags_first_edge", 3'b101);

    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [5:0]  f;
      logic [31:0] x, y;
      op = 2'($urandom_range(0, 3));
      f  = pick_funct();
      x  = pick_operand();
      y  = pick_operand();
      model(op, f, x, y, mg, mr, mv);
      @(negedge clk);
      aluop = op; funct = f; a = x; b = y;
      pc = $urandom(); imm_ext = 32'($signed(16'($urandom())));
      mpc  = pc + 32'd4;
      mimm = imm_ext * 32'd4;
      #1;
      chk("rnd_gout", 32'(gout), 32'(mg));
      chk("rnd_result", alu_result, mr);
      chk("rnd_vout", 32'(vout), 32'(mv));
      chk("rnd_zout", 32'(zout), 32'(mr == 32'h0));
      chk("rnd_nout", 32'(nout), 32'(mr[31]));
      chk("rnd_pc_plus4", pc_plus4, mpc);
      chk("rnd_branch", branch_target, mpc + mimm);
      @(posedge clk); #1;
      chk_flags("rnd_flags", {mv, mr == 32'h0, mr[31]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
